alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencing front-end that drives the combinational 3-bit-select ALU and collects its result. It accepts abstract commands on a valid/ready interface and encodes each opcode into the ALU select field. It runs one ALU pass, or two passes for SUB, then returns the result and zero flag on a second valid/ready interface. It sits between the decode/issue stage and the ALU instance.

Parameters:
- WIDTH, 32, operand/result width; must match the attached ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high at a clk edge.
- cmd_op  in  4  abstract opcode.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  ALU data_a.
- alu_b  out  WIDTH  ALU data_b.
- alu_sel  out  3  ALU select.
- alu_y  in  WIDTH  ALU result.
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_y  out  WIDTH  result.
- rsp_zero  out  1  result == 0.
- rsp_err  out  1  illegal opcode.

Behaviour:
- Clock/reset: one clock domain; reset is asynchronous, active-low.
- Opcode encoding, cmd_op -> alu_sel:
  - 0 ADD -> 001
  - 1 AND -> 010
  - 2 OR -> 011
  - 3 XOR -> 100
  - 4 SLTU -> 101 (unsigned compare; result 1 or 0)
  - 5 MUL -> 110 (low WIDTH bits)
  - 6 MOVA -> 111
  - 7 SUB -> two passes of 001
  - 8..15 illegal
- Registers: command is latched into op_q, a_q, b_q on acceptance; all ALU outputs are driven from registers and combinational state decode.
- FSM states: IDLE, EXEC1, EXEC2, RESP.
  - IDLE: cmd_ready=1; alu_sel=000. On accept: legal op -> EXEC1; illegal op -> RESP with rsp_y=0, rsp_zero=1, rsp_err=1. No ALU pass for illegal ops.
  - EXEC1: alu_a=a_q. alu_b=b_q, or ~b_q for SUB. alu_sel per table. At the edge, capture alu_y and alu_zero into rsp_y and rsp_zero, rsp_err=0. SUB -> EXEC2; otherwise -> RESP.
  - EXEC2 (SUB only): alu_a=rsp_y (pass-1 sum), alu_b=1, alu_sel=001. At the edge, recapture rsp_y and rsp_zero -> RESP. Result is a - b modulo 2^WIDTH.
  - RESP: rsp_valid=1. rsp_y, rsp_zero and rsp_err are stable until the handshake. On rsp_valid && rsp_ready -> IDLE.
- cmd_ready is high only in IDLE, so at most one command is in flight. A command cannot be accepted in the same cycle a response completes.
- Latency, counting edges after the accept edge until rsp_valid is high: legal single-pass = 2, SUB = 3, illegal = 1. If rsp_ready is held high, the minimum issue interval is 3, 4 and 2 cycles respectively.
- alu_a and alu_b hold their last values outside EXEC states. alu_sel=000 outside EXEC states.
- rsp_zero is taken from alu_zero, never recomputed locally, except for illegal ops where it is forced to 1.
- Reset values: state=IDLE, cmd_ready=1 (combinational from state), rsp_valid=0, rsp_y=0, rsp_zero=0, rsp_err=0, alu_a=0, alu_b=0, alu_sel=000, op_q/a_q/b_q=0.
- Reset asserted mid-operation (EXEC1, EXEC2 or RESP): the pending command and response are discarded and rsp_valid drops immediately (asynchronous). No response is ever issued for that command.
- Back-pressure: rsp_ready low in RESP holds every rsp_* output and keeps cmd_ready=0 indefinitely.
- cmd_valid while cmd_ready=0 is ignored. The sender must hold the command; this block does not sample it.

Test Plan:
- ADD, a=0x0000_0005, b=0x0000_0003, rsp_ready=1 -> alu_sel=001 in EXEC1; rsp_valid 2 edges after accept; rsp_y=0x8, rsp_zero=0, rsp_err=0.
- SUB, a=0x10, b=0x10 -> pass 1 drives alu_b=0xFFFF_FFEF; pass 2 drives alu_b=1; rsp_y=0, rsp_zero=1; latency 3. Then SUB, a=0, b=1 -> rsp_y=0xFFFF_FFFF, rsp_zero=0.
- SLTU, a=0xFFFF_FFFF, b=1 -> rsp_y=0 (unsigned), rsp_zero=1. MUL, a=0x1_0000, b=0x1_0000 -> rsp_y=0, rsp_zero=1 (truncated).
- Illegal op 0xC -> no EXEC cycle, alu_sel stays 000; rsp_valid 1 edge after accept; rsp_err=1, rsp_y=0, rsp_zero=1.
- Back-pressure: OR, a=0xF0, b=0x0F, rsp_ready=0 for 5 cycles -> rsp_y=0xFF held, cmd_ready=0 throughout. A second command presented meanwhile is not accepted until the cycle after rsp_ready=1.
- Reset during EXEC2 of a SUB -> rsp_valid=0 and rsp_y=0 immediately; after rst_n release, state IDLE, cmd_ready=1, no stale response emitted.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - command sequencer for the 3-bit-select combinational ALU
module alu_issue_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_y,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic             rsp_zero,
   output logic             rsp_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXEC1 = 2'd1,
      EXEC2 = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] OP_SUB  = 4'd7;
   localparam logic [2:0] SEL_NOP = 3'b000;
   localparam logic [2:0] SEL_ADD = 3'b001;
   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           state;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] alu_a_hold;
   logic [WIDTH-1:0] alu_b_hold;
   logic             op_is_sub;

   // Abstract opcode to ALU select; SUB rides on ADD, illegal codes select nothing
   function automatic logic [2:0] encode_op(input logic [3:0] op);
      logic [2:0] sel;
      case (op)
         4'd0:    sel = 3'b001;
         4'd1:    sel = 3'b010;
         4'd2:    sel = 3'b011;
         4'd3:    sel = 3'b100;
         4'd4:    sel = 3'b101;
         4'd5:    sel = 3'b110;
         4'd6:    sel = 3'b111;
         4'd7:    sel = 3'b001;
         default: sel = 3'b000;
      endcase
      return sel;
   endfunction

   assign op_is_sub = (op_q == OP_SUB);
   assign cmd_ready = (state == IDLE);

   // ALU operand/select decode: pass 1 uses the latched command, pass 2 adds the +1 of two's complement
   always_comb begin
      alu_a   = alu_a_hold;
      alu_b   = alu_b_hold;
      alu_sel = SEL_NOP;
      case (state)
         EXEC1: begin
            alu_a   = a_q;
            alu_b   = op_is_sub ? ~b_q : b_q;
            alu_sel = encode_op(op_q);
         end
         EXEC2: begin
            alu_a   = rsp_y;
            alu_b   = ONE;
            alu_sel = SEL_ADD;
         end
         default: begin
            alu_a   = alu_a_hold;
            alu_b   = alu_b_hold;
            alu_sel = SEL_NOP;
         end
      endcase
   end

   // Sequencer FSM with registered response and operand-hold registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         alu_a_hold <= '0;
         alu_b_hold <= '0;
         rsp_valid  <= 1'b0;
         rsp_y      <= '0;
         rsp_zero   <= 1'b0;
         rsp_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_q <= cmd_op;
                  a_q  <= cmd_a;
                  b_q  <= cmd_b;
                  if (cmd_op[3]) begin
                     // Illegal opcode: answer directly, the ALU is never exercised
                     rsp_y     <= '0;
                     rsp_zero  <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end else begin
                     state <= EXEC1;
                  end
               end
            end
            EXEC1: begin
               rsp_y      <= alu_y;
               rsp_zero   <= alu_zero;
               rsp_err    <= 1'b0;
               alu_a_hold <= alu_a;
               alu_b_hold <= alu_b;
               if (op_is_sub) begin
                  state <= EXEC2;
               end else begin
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            EXEC2: begin
               rsp_y      <= alu_y;
               rsp_zero   <= alu_zero;
               alu_a_hold <= alu_a;
               alu_b_hold <= alu_b;
               rsp_valid  <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl
module tb_alu_issue_ctrl;

   localparam int WIDTH = 32;

   logic             clk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_op;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [2:0]       alu_sel;
   logic [WIDTH-1:0] alu_y;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_y;
   logic             rsp_zero;
   logic             rsp_err;

   int checks = 0;
   int errors = 0;
   int lat;
   int nexec;
   logic [2:0]       tr_sel [4];
   logic [WIDTH-1:0] tr_a   [4];
   logic [WIDTH-1:0] tr_b   [4];
   logic [2:0]       first_sel;

   alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_sel   (alu_sel),
      .alu_y     (alu_y),
      .alu_zero  (alu_zero),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .rsp_zero  (rsp_zero),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the attached combinational ALU
   always_comb begin
      alu_y = '0;
      case (alu_sel)
         3'b001: alu_y = alu_a + alu_b;
         3'b010: alu_y = alu_a & alu_b;
         3'b011: alu_y = alu_a | alu_b;
         3'b100: alu_y = alu_a ^ alu_b;
         3'b101: alu_y = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
         3'b110: alu_y = alu_a * alu_b;
         3'b111: alu_y = alu_a;
         default: alu_y = '0;
      endcase
      alu_zero = (alu_y == '0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Present a command, wait for acceptance, then count edges until rsp_valid while tracing the ALU drive
   task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n;
      @(negedge clk);
      cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      first_sel = alu_sel;
      lat = 1;
      nexec = 0;
      while (!rsp_valid && lat < 10) begin
         if (nexec < 4) begin
            tr_sel[nexec] = alu_sel;
            tr_a[nexec]   = alu_a;
            tr_b[nexec]   = alu_b;
         end
         nexec++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic expect_rsp(input string tag, input int exp_lat, input logic [WIDTH-1:0] y,
                             input logic z, input logic e);
      check({tag, "_lat"},  64'(lat), 64'(exp_lat));
      check({tag, "_y"},    64'(rsp_y), 64'(y));
      check({tag, "_zero"}, {63'd0, rsp_zero}, {63'd0, z});
      check({tag, "_err"},  {63'd0, rsp_err}, {63'd0, e});
   endtask

   task automatic consume(input string tag);
      @(posedge clk); #1;
      check({tag, "_drop"}, {63'd0, rsp_valid}, 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {63'd0, rsp_valid}, 64'd0);
      check("rst_ready", {63'd0, cmd_ready}, 64'd1);
      check("rst_y",     64'(rsp_y), 64'd0);
      check("rst_sel",   64'(alu_sel), 64'd0);
      check("rst_a",     64'(alu_a), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // ADD 5+3
      issue(4'd0, 32'h5, 32'h3);
      check("add_sel", 64'(tr_sel[0]), 64'd1);
      expect_rsp("add", 2, 32'h8, 1'b0, 1'b0);
      consume("add");

      // SUB 0x10-0x10: two passes
      issue(4'd7, 32'h10, 32'h10);
      check("sub_p1_b",   64'(tr_b[0]), 64'hFFFF_FFEF);
      check("sub_p1_sel", 64'(tr_sel[0]), 64'd1);
      check("sub_p2_a",   64'(tr_a[1]), 64'hFFFF_FFFF);
      check("sub_p2_b",   64'(tr_b[1]), 64'd1);
      check("sub_p2_sel", 64'(tr_sel[1]), 64'd1);
      expect_rsp("sub0", 3, 32'h0, 1'b1, 1'b0);
      consume("sub0");

      // SUB 0-1 wraps
      issue(4'd7, 32'h0, 32'h1);
      expect_rsp("subw", 3, 32'hFFFF_FFFF, 1'b0, 1'b0);
      consume("subw");

      // SLTU unsigned compare
      issue(4'd4, 32'hFFFF_FFFF, 32'h1);
      check("sltu_sel", 64'(tr_sel[0]), 64'd5);
      expect_rsp("sltu", 2, 32'h0, 1'b1, 1'b0);
      consume("sltu");

      // MUL truncation
      issue(4'd5, 32'h0001_0000, 32'h0001_0000);
      expect_rsp("mul", 2, 32'h0, 1'b1, 1'b0);
      consume("mul");

      // MOVA and XOR
      issue(4'd6, 32'hDEAD_BEEF, 32'h1234_5678);
      expect_rsp("mova", 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
      consume("mova");
      issue(4'd3, 32'hFF00_FF00, 32'hFF00_FF00);
      expect_rsp("xor", 2, 32'h0, 1'b1, 1'b0);
      consume("xor");

      // Illegal opcode: no ALU pass
      issue(4'hC, 32'h1234, 32'h5678);
      check("ill_sel", 64'(first_sel), 64'd0);
      check("ill_nexec", 64'(nexec), 64'd0);
      expect_rsp("ill", 1, 32'h0, 1'b1, 1'b1);
      consume("ill");

      // Back-pressure: OR held with rsp_ready low, second command waiting
      rsp_ready = 1'b0;
      issue(4'd2, 32'hF0, 32'h0F);
      expect_rsp("or", 2, 32'hFF, 1'b0, 1'b0);
      cmd_op = 4'd0; cmd_a = 32'h1; cmd_b = 32'h2; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_valid", {63'd0, rsp_valid}, 64'd1);
         check("bp_y",     64'(rsp_y), 64'hFF);
         check("bp_ready", {63'd0, cmd_ready}, 64'd0);
      end
      @(negedge clk); rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_hs_valid", {63'd0, rsp_valid}, 64'd0);
      check("bp_hs_ready", {63'd0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
      check("bp_acc_ready", {63'd0, cmd_ready}, 64'd0);
      check("bp_acc_sel",   64'(alu_sel), 64'd1);
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("bp2_valid", {63'd0, rsp_valid}, 64'd1);
      check("bp2_y",     64'(rsp_y), 64'h3);
      consume("bp2");

      // Reset during EXEC2 of a SUB
      @(negedge clk);
      cmd_op = 4'd7; cmd_a = 32'h5; cmd_b = 32'h3; cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("rstm_exec2_sel", 64'(alu_sel), 64'd1);
      check("rstm_exec2_b",   64'(alu_b), 64'd1);
      check("rstm_pass1_y",   64'(rsp_y), 64'd1);
      #2; rst_n = 1'b0;
      #1;
      check("rstm_valid", {63'd0, rsp_valid}, 64'd0);
      check("rstm_y",     64'(rsp_y), 64'd0);
      check("rstm_sel",   64'(alu_sel), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("rstm_no_rsp", {63'd0, rsp_valid}, 64'd0);
         check("rstm_idle",   {63'd0, cmd_ready}, 64'd1);
      end

      // Normal operation resumes
      issue(4'd1, 32'hF0F0, 32'h0FF0);
      expect_rsp("and", 2, 32'h00F0, 1'b0, 1'b0);
      consume("and");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
